hazard_ctl: RTL and testbench

- Pipeline hazard controller for the decode stage.
- Keeps a per-register scoreboard of in-flight GP and SR writes, recorded at issue and released at writeback.
- Holds the PC and the ID latch on read-after-write hazards, on scoreboard saturation and on memory wait.
- On a taken branch, clears the IF/ID path and bubbles the ID→EX hand-off for a programmable window; it is the sole driver of the decode stage's `iw_stall` and `iw_flush` inputs.

---
 rtl/hazard_ctl_pkg.sv | 9 +
 rtl/hz_scoreboard.sv | 39 +++
 rtl/hazard_ctl.sv | 90 +++++++++
 tb/tb_hazard_ctl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/hazard_ctl_pkg.sv
// hazard_ctl_pkg: shared types and sizes for the decode-stage hazard controller.
package hazard_ctl_pkg;
  typedef enum logic {HZ_IDLE, HZ_FLUSH} hz_state_e;
  localparam int CNT_W_DEF  = 2;
  localparam int NUM_GP_DEF = 16;
  localparam int NUM_SR_DEF = 4;
  localparam int GP_IDX_W   = $clog2(NUM_GP_DEF);
  localparam int SR_IDX_W   = $clog2(NUM_SR_DEF);
endpackage

// File: rtl/hz_scoreboard.sv
// hz_scoreboard: per-register pending-write counters with two busy lookups and a saturation flag.
module hz_scoreboard
  import hazard_ctl_pkg::*;
#(
  parameter int N     = NUM_GP_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int IW    = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic          rt_en_i,
  input  logic [IW-1:0] rt_idx_i,
  input  logic [IW-1:0] rd_a_idx_i,
  input  logic [IW-1:0] rd_b_idx_i,
  output logic          busy_a_o,
  output logic          busy_b_o,
  output logic          sat_o
);
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  // A retire at zero is dropped; the assertion below flags it in simulation.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (wr_en_i && wr_idx_i == IW'(i)) cnt_d[i] = cnt_d[i] + CNT_W'(1);
      if (rt_en_i && rt_idx_i == IW'(i) && cnt_q[i] != '0) cnt_d[i] = cnt_d[i] - CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    else        for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
  end
  assign busy_a_o = cnt_q[rd_a_idx_i] != '0;
  assign busy_b_o = cnt_q[rd_b_idx_i] != '0;
  assign sat_o    = &cnt_q[wr_idx_i];
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) rt_en_i |-> cnt_q[rt_idx_i] != '0);
endmodule

// File: rtl/hazard_ctl.sv
// hazard_ctl: decode-stage stall/flush control with GP/SR write scoreboards and a branch flush window.
module hazard_ctl
  import hazard_ctl_pkg::*;
#(
  parameter int NUM_GP       = NUM_GP_DEF,
  parameter int NUM_SR       = NUM_SR_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                      iw_clk,
  input  logic                      iw_rst_n,
  input  logic                      iw_id_valid,
  input  logic                      iw_id_opc_nop,
  input  logic                      iw_id_has_src_gp,
  input  logic [$clog2(NUM_GP)-1:0] iw_id_src_gp,
  input  logic                      iw_id_rd_tgt_gp,
  input  logic [$clog2(NUM_GP)-1:0] iw_id_tgt_gp,
  input  logic                      iw_id_tgt_gp_we,
  input  logic                      iw_id_has_src_sr,
  input  logic [SR_IDX_W-1:0]       iw_id_src_sr,
  input  logic [SR_IDX_W-1:0]       iw_id_tgt_sr,
  input  logic                      iw_id_tgt_sr_we,
  input  logic                      iw_wb_gp_we,
  input  logic [$clog2(NUM_GP)-1:0] iw_wb_gp_idx,
  input  logic                      iw_wb_sr_we,
  input  logic [SR_IDX_W-1:0]       iw_wb_sr_idx,
  input  logic                      iw_br_taken,
  input  logic                      iw_mem_busy,
  output logic                      ow_stall_pc,
  output logic                      ow_stall_id,
  output logic                      ow_stall_ex,
  output logic                      ow_flush_id,
  output logic                      ow_bubble_ex,
  output logic                      ow_issue,
  output logic [15:0]               ow_stall_cnt
);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  hz_state_e   state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [15:0] scnt_q, scnt_d;
  logic gp_busy_s, gp_busy_t, gp_sat, sr_busy_s, sr_busy_t, sr_sat;
  logic raw, hazard, flush, issue;
  hz_scoreboard #(.N(NUM_GP), .CNT_W(CNT_W)) u_gp (
    .clk(iw_clk), .rst_n(iw_rst_n),
    .wr_en_i(issue & iw_id_tgt_gp_we), .wr_idx_i(iw_id_tgt_gp),
    .rt_en_i(iw_wb_gp_we), .rt_idx_i(iw_wb_gp_idx),
    .rd_a_idx_i(iw_id_src_gp), .rd_b_idx_i(iw_id_tgt_gp),
    .busy_a_o(gp_busy_s), .busy_b_o(gp_busy_t), .sat_o(gp_sat)
  );
  hz_scoreboard #(.N(NUM_SR), .CNT_W(CNT_W), .IW(SR_IDX_W)) u_sr (
    .clk(iw_clk), .rst_n(iw_rst_n),
    .wr_en_i(issue & iw_id_tgt_sr_we), .wr_idx_i(iw_id_tgt_sr),
    .rt_en_i(iw_wb_sr_we), .rt_idx_i(iw_wb_sr_idx),
    .rd_a_idx_i(iw_id_src_sr), .rd_b_idx_i(iw_id_tgt_sr),
    .busy_a_o(sr_busy_s), .busy_b_o(sr_busy_t), .sat_o(sr_sat)
  );
  // Busy flags come from registered counts only, so a same-cycle writeback never bypasses.
  assign raw    = (iw_id_has_src_gp & gp_busy_s) | (iw_id_rd_tgt_gp & gp_busy_t)
                | (iw_id_has_src_sr & sr_busy_s) | (iw_id_tgt_sr_we & sr_busy_t);
  assign hazard = iw_id_valid & ~iw_id_opc_nop
                & (raw | (iw_id_tgt_gp_we & gp_sat) | (iw_id_tgt_sr_we & sr_sat));
  assign flush  = iw_br_taken | (state_q == HZ_FLUSH);
  assign issue  = iw_rst_n & iw_id_valid & ~hazard & ~iw_mem_busy & ~flush;
  always_comb begin
    state_d = iw_br_taken ? HZ_FLUSH
            : (state_q == HZ_FLUSH && fcnt_q == '0) ? HZ_IDLE : state_q;
    fcnt_d  = iw_br_taken ? FW'(FLUSH_CYCLES - 1)
            : (fcnt_q != '0) ? fcnt_q - FW'(1) : fcnt_q;
    scnt_d  = (hazard & ~flush & ~iw_mem_busy & (scnt_q != 16'hFFFF)) ? scnt_q + 16'd1 : scnt_q;
  end
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q <= HZ_IDLE;
      fcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      scnt_q  <= scnt_d;
    end
  end
  // Gating with reset keeps the pass-through outputs quiet while reset is held.
  assign ow_flush_id  = iw_rst_n & flush;
  assign ow_stall_pc  = iw_rst_n & ~flush & (iw_mem_busy | hazard);
  assign ow_stall_id  = ow_stall_pc;
  assign ow_stall_ex  = iw_rst_n & iw_mem_busy;
  assign ow_bubble_ex = iw_rst_n & ~iw_mem_busy & ~issue;
  assign ow_issue     = issue;
  assign ow_stall_cnt = scnt_q;
endmodule

// File: tb/tb_hazard_ctl.sv
// tb_hazard_ctl: directed vector table plus hand sequences for flush and reset corner cases.
module tb_hazard_ctl;
  import hazard_ctl_pkg::*;
  logic iw_clk = 0, iw_rst_n = 0;
  logic valid, nop, hs_gp, rd_tgt, tgt_we, hs_sr, tsr_we, wb_gp_we, wb_sr_we, br, mem;
  logic [GP_IDX_W-1:0] src_gp, tgt_gp, wb_gp;
  logic [SR_IDX_W-1:0] src_sr, tgt_sr, wb_sr;
  logic spc, sid, sex, fl, bub, iss;
  logic [15:0] scnt;
  logic [5:0] outs;
  int checks = 0, errors = 0;
  always #5 iw_clk = ~iw_clk;
  assign outs = {spc, sid, sex, fl, bub, iss};
  hazard_ctl dut (
    .iw_clk(iw_clk), .iw_rst_n(iw_rst_n), .iw_id_valid(valid), .iw_id_opc_nop(nop),
    .iw_id_has_src_gp(hs_gp), .iw_id_src_gp(src_gp), .iw_id_rd_tgt_gp(rd_tgt),
    .iw_id_tgt_gp(tgt_gp), .iw_id_tgt_gp_we(tgt_we), .iw_id_has_src_sr(hs_sr),
    .iw_id_src_sr(src_sr), .iw_id_tgt_sr(tgt_sr), .iw_id_tgt_sr_we(tsr_we),
    .iw_wb_gp_we(wb_gp_we), .iw_wb_gp_idx(wb_gp), .iw_wb_sr_we(wb_sr_we), .iw_wb_sr_idx(wb_sr),
    .iw_br_taken(br), .iw_mem_busy(mem), .ow_stall_pc(spc), .ow_stall_id(sid),
    .ow_stall_ex(sex), .ow_flush_id(fl), .ow_bubble_ex(bub), .ow_issue(iss), .ow_stall_cnt(scnt)
  );
  typedef struct {
    string name;
    logic valid, nop, hs_gp, rd_tgt, tgt_we, hs_sr, tsr_we, wb_gp_we, wb_sr_we, mem;
    logic [GP_IDX_W-1:0] src_gp, tgt_gp, wb_gp;
    logic [SR_IDX_W-1:0] src_sr, tgt_sr, wb_sr;
    logic [5:0]  exp;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t gv(string n, bit v, bit hs, int sg, bit rt, int tg, bit we,
                              bit wbe, int wbi, bit m, logic [5:0] e, int c);
    vec_t t;
    t.name = n; t.valid = v; t.nop = 0; t.hs_gp = hs; t.src_gp = GP_IDX_W'(sg);
    t.rd_tgt = rt; t.tgt_gp = GP_IDX_W'(tg); t.tgt_we = we; t.wb_gp_we = wbe;
    t.wb_gp = GP_IDX_W'(wbi); t.mem = m; t.hs_sr = 0; t.src_sr = 0; t.tgt_sr = 0;
    t.tsr_we = 0; t.wb_sr_we = 0; t.wb_sr = 0; t.exp = e; t.exp_cnt = 16'(c);
    return t;
  endfunction
  function automatic vec_t sv(string n, bit hs, int ss, int ts, bit twe, bit wbe, int wbi,
                              logic [5:0] e, int c);
    vec_t t = gv(n, 1, 0, 0, 0, 0, 0, 0, 0, 0, e, c);
    t.hs_sr = hs; t.src_sr = SR_IDX_W'(ss); t.tgt_sr = SR_IDX_W'(ts); t.tsr_we = twe;
    t.wb_sr_we = wbe; t.wb_sr = SR_IDX_W'(wbi);
    return t;
  endfunction
  task automatic apply(vec_t t);
    valid = t.valid; nop = t.nop; hs_gp = t.hs_gp; src_gp = t.src_gp; rd_tgt = t.rd_tgt;
    tgt_gp = t.tgt_gp; tgt_we = t.tgt_we; hs_sr = t.hs_sr; src_sr = t.src_sr;
    tgt_sr = t.tgt_sr; tsr_we = t.tsr_we; wb_gp_we = t.wb_gp_we; wb_gp = t.wb_gp;
    wb_sr_we = t.wb_sr_we; wb_sr = t.wb_sr; mem = t.mem; br = 0;
  endtask
  task automatic cmp(string n, logic [5:0] e, logic [15:0] c);
    checks++;
    if (outs !== e) begin
      errors++;
      $display("FAIL %s: outputs {spc,sid,sex,fl,bub,iss}=%b expected %b", n, outs, e);
    end
    checks++;
    if (scnt !== c) begin
      errors++;
      $display("FAIL %s: stall_cnt=%0d expected %0d", n, scnt, c);
    end
  endtask
  task automatic chk(string n, logic [5:0] e, logic [15:0] c);
    @(negedge iw_clk);
    cmp(n, e, c);
    @(posedge iw_clk);
    #1;
  endtask
  vec_t t;
  initial begin
    apply(gv("", 1, 1, 3, 1, 3, 1, 0, 0, 1, 0, 0));
    br = 1;
    #2 cmp("reset_hold", 6'b000000, 16'd0);
    @(posedge iw_clk); @(posedge iw_clk); #1;
    iw_rst_n = 1;
    tv.push_back(gv("iss_w3",     1, 0, 0, 0, 3, 1, 0, 0, 0, 6'b000001, 0));
    tv.push_back(gv("raw_r3",     1, 1, 3, 0, 4, 1, 0, 0, 0, 6'b110010, 0));
    tv.push_back(gv("raw_r3_wb",  1, 1, 3, 0, 4, 1, 1, 3, 0, 6'b110010, 1));
    tv.push_back(gv("raw_r3_iss", 1, 1, 3, 0, 4, 1, 0, 0, 0, 6'b000001, 2));
    tv.push_back(gv("iss_w5",     1, 0, 0, 0, 5, 1, 0, 0, 0, 6'b000001, 2));
    tv.push_back(gv("rdtgt_r5",   1, 0, 0, 1, 5, 1, 0, 0, 0, 6'b110010, 2));
    tv.push_back(gv("we_only_r5", 1, 0, 0, 0, 5, 1, 0, 0, 0, 6'b000001, 3));
    t = gv("nop_r5", 1, 1, 5, 0, 0, 0, 0, 0, 0, 6'b000001, 3);
    t.nop = 1;
    tv.push_back(t);
    tv.push_back(gv("bubble_id",  0, 1, 5, 0, 0, 0, 0, 0, 0, 6'b000010, 3));
    tv.push_back(gv("w1_a",       1, 0, 0, 0, 1, 1, 0, 0, 0, 6'b000001, 3));
    tv.push_back(gv("w1_b",       1, 0, 0, 0, 1, 1, 0, 0, 0, 6'b000001, 3));
    tv.push_back(gv("w1_c",       1, 0, 0, 0, 1, 1, 0, 0, 0, 6'b000001, 3));
    tv.push_back(gv("sat_r1",     1, 0, 0, 0, 1, 1, 0, 0, 0, 6'b110010, 3));
    tv.push_back(gv("sat_r1_wb",  1, 0, 0, 0, 1, 1, 1, 1, 0, 6'b110010, 4));
    tv.push_back(gv("sat_r1_iss", 1, 0, 0, 0, 1, 1, 0, 0, 0, 6'b000001, 5));
    for (int i = 0; i < 4; i++)
      tv.push_back(gv($sformatf("mem_hz%0d", i), 1, 1, 1, 0, 0, 0, 0, 0, 1, 6'b111000, 5));
    tv.push_back(gv("hz_after_mem", 1, 1, 1, 0, 0, 0, 0, 0, 0, 6'b110010, 5));
    tv.push_back(gv("mem_nohz",     1, 1, 7, 0, 0, 0, 0, 0, 1, 6'b111000, 6));
    tv.push_back(sv("sr_w2",       0, 0, 2, 1, 0, 0, 6'b000001, 6));
    tv.push_back(sv("sr_src2",     1, 2, 0, 0, 0, 0, 6'b110010, 6));
    tv.push_back(sv("sr_tgt2_wb",  0, 0, 2, 1, 1, 2, 6'b110010, 7));
    tv.push_back(sv("sr_tgt2_iss", 0, 0, 2, 1, 0, 0, 6'b000001, 8));
    foreach (tv[i]) begin
      apply(tv[i]);
      chk(tv[i].name, tv[i].exp, tv[i].exp_cnt);
    end
    // Branch flush over a live r5 hazard: flush wins, stall counter frozen.
    apply(gv("", 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0));
    br = 1; chk("flush_a0", 6'b000110, 8);
    br = 0; chk("flush_a1", 6'b000110, 8);
    chk("flush_a2", 6'b000110, 8);
    chk("flush_a_end", 6'b110010, 8);
    // Second pulse in cycle 2 stretches the window to cycle 4.
    apply(gv("", 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    br = 1; chk("flush_b0", 6'b000110, 9);
    br = 0; chk("flush_b1", 6'b000110, 9);
    br = 1; chk("flush_b2", 6'b000110, 9);
    br = 0; chk("flush_b3", 6'b000110, 9);
    chk("flush_b4", 6'b000110, 9);
    chk("flush_b_end", 6'b000001, 9);
    // Reset dropped mid-flush with r2 pending.
    apply(gv("", 1, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
    chk("iss_w2", 6'b000001, 9);
    apply(gv("", 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    br = 1; chk("rst_flush0", 6'b000110, 9);
    br = 0; mem = 1;
    #2 iw_rst_n = 0;
    #1 cmp("rst_async", 6'b000000, 0);
    @(negedge iw_clk);
    cmp("rst_held", 6'b000000, 0);
    @(posedge iw_clk); #1;
    iw_rst_n = 1;
    apply(gv("", 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("post_rst_r2", 6'b000001, 0);
    apply(gv("", 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    chk("post_rst_w1", 6'b000001, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
